nibble_serial_adder_ctrl: RTL and testbench

NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

---
 rtl/nibble_serial_adder_ctrl.sv | 156 +++++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_adder_ctrl
//  Purpose  : W-bit adder (W = 4*NIBBLES) built from a single 4-bit ripple
//             slice that is reused once per nibble, LSB nibble first.
//             Optional macro SUBTRACT_EN enables A - B through the sub port.
//  Revision : 1.0  initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sub,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    work_q, work_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [W-1:0]    b_eff;
    logic            cin_eff;
    logic [3:0]      slice_a, slice_b, slice_s;
    logic [4:0]      slice_c;

    // Operand conditioning at accept time: subtract is A + ~B + 1
`ifdef SUBTRACT_EN
    always_comb begin
        b_eff   = sub ? ~b : b;
        cin_eff = sub ? 1'b1 : cin;
    end
`else
    logic unused_sub;
    always_comb begin
        b_eff      = b;
        cin_eff    = cin;
        unused_sub = sub;
    end
`endif

    // The one shared 4-bit ripple slice, fed by the current nibble and carry
    always_comb begin
        slice_a    = a_q[{idx_q, 2'b00} +: 4];
        slice_b    = b_q[{idx_q, 2'b00} +: 4];
        slice_c    = '0;
        slice_s    = '0;
        slice_c[0] = carry_q;
        for (int i = 0; i < 4; i++) begin
            slice_s[i]   = slice_a[i] ^ slice_b[i] ^ slice_c[i];
            slice_c[i+1] = (slice_a[i] & slice_b[i]) |
                           (slice_a[i] & slice_c[i]) |
                           (slice_b[i] & slice_c[i]);
        end
    end

    // Next-state and datapath updates; results only move into sum on the last nibble
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = cin_eff;
                    idx_d   = '0;
                    work_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                work_d[{idx_q, 2'b00} +: 4] = slice_s;
                carry_d = slice_c[4];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                    sum_d   = work_d;
                    cout_d  = slice_c[4];
                    ovf_d   = slice_c[3] ^ slice_c[4];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with immediate clear on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nibble_serial_adder_ctrl
//  Purpose  : Self-checking bench for nibble_serial_adder_ctrl (NIBBLES=4):
//             directed vector table, reset/back-to-back sequences and
//             randomized operations against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         reset, start, sub, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int n_cmp  = 0;
    int n_fail = 0;

    nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain W-bit arithmetic; overflow from operand/result signs
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mcin,
                         input logic msub, output logic [W-1:0] ms, output logic mc,
                         output logic mo);
        logic [W:0]   r;
        logic [W-1:0] bb;
        logic         cc;
        bb = mb;
        cc = mcin;
`ifdef SUBTRACT_EN
        if (msub) begin
            bb = ~mb;
            cc = 1'b1;
        end
`endif
        r  = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, cc};
        ms = r[W-1:0];
        mc = r[W];
        mo = (ma[W-1] == bb[W-1]) && (ms[W-1] != ma[W-1]);
    endtask

    // One operation from IDLE; optionally scrambles inputs and re-pulses start while busy
    task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vcin, input logic vsub, input bit scramble,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int           cnt;
        bit           got;
        bit           hold_bad;
        logic [W-1:0] prev;
        prev     = sum;
        hold_bad = 1'b0;
        @(negedge clk);
        a = va; b = vb; cin = vcin; sub = vsub; start = 1'b1;
        @(posedge clk); #1;
        check({name, " busy_after_start"}, 32'(busy), 32'd1);
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 20) begin
            @(negedge clk);
            if (scramble) begin
                a     = W'($urandom);
                b     = W'($urandom);
                cin   = 1'($urandom);
                sub   = 1'($urandom);
                start = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cnt++;
            if (done) got = 1'b1;
            else if (sum !== prev) hold_bad = 1'b1;
        end
        check({name, " latency"}, 32'(cnt), 32'(NIBBLES));
        check({name, " sum_held"}, 32'(hold_bad), 32'd0);
        check({name, " sum"}, 32'(sum), 32'(es));
        check({name, " cout"}, 32'(cout), 32'(ec));
        check({name, " ovf"}, 32'(ovf), 32'(eo));
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check({name, " idle_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        logic [W-1:0] ms;
        logic         mc, mo;
        int           ndone, last_t, t;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
`ifdef SUBTRACT_EN
        vecs[6] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
`else
        vecs[6] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8002, 1'b0, 1'b0};
`endif

        reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {13'd0, busy, done, cout, ovf, sum}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_start", {30'd0, busy, done}, 32'd0);

        // Directed table
        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   1'b0, vecs[i].es, vecs[i].ec, vecs[i].eo);

        // Operands changed and start re-pulsed while busy: original result stands
        run_op("scramble", 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);

        // Asynchronous reset between edges 2 and 3 of a run
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_reset_outputs", {13'd0, busy, done, cout, ovf, sum}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("no_done_after_abort", 32'(ndone), 32'd0);
        run_op("after_reset", 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

        // start held high: done every NIBBLES+2 cycles
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
        ndone  = 0;
        last_t = -1;
        for (t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                check("b2b_sum", 32'(sum), 32'h2);
                if (last_t >= 0) check("b2b_period", 32'(t - last_t), 32'(NIBBLES + 2));
                last_t = t;
            end
        end
        check("b2b_count", 32'(ndone), 32'd3);
        @(negedge clk);
        start = 1'b0;
        repeat (NIBBLES + 3) @(posedge clk);
        #1;

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc, rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            model(ra, rb, rc, rs, ms, mc, mo);
            run_op($sformatf("rand%0d", i), ra, rb, rc, rs, 1'(i % 2), ms, mc, mo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
